program_counter_stack: RTL
==========================

# program_counter_stack

Parametrised SAP-1 program counter with a hardware return-address stack, adding CALL/RETURN support to the increment/load/halt counter. It sits in the control path between the microcode sequencer, which issues one command per micro-step, and the memory address register, which consumes `o_data`. Width, stack depth and overflow/underflow handling are parameters or status outputs, so wider-address SAP variants use the same block.

## Interface
Parameters:
- `WIDTH`, 4: counter and address width in bits; ≥2.
- `DEPTH`, 4: return-stack entries; ≥1.
- `DW`, $clog2(DEPTH+1): derived localparam, width of the depth count.

Ports:
- `mclk` input 1: master clock; all state updates on posedge.
- `i_reset` input 1: synchronous, active-high reset; overrides every other input.
- `mclk_en` input 1: clock enable; when low, all state holds.
- `i_counter_enable` input 1: increment request.
- `i_halt` input 1: freeze request; blocks every command except reset.
- `i_load_enable` input 1: jump to `i_load_data`.
- `i_call` input 1: push return address, then jump to `i_load_data`.
- `i_return` input 1: pop the top of stack into the counter.
- `i_load_data` input WIDTH: jump/call target.
- `o_data` output WIDTH: current counter value.
- `o_depth` output DW: number of occupied stack entries.
- `o_stack_empty` output 1: `o_depth == 0`.
- `o_stack_full` output 1: `o_depth == DEPTH`.
- `o_overflow` output 1: sticky; a CALL was issued while the stack was full.
- `o_underflow` output 1: sticky; a RETURN was issued while the stack was empty.

## Operation
- Reset: `o_data`=0, `o_depth`=0, `o_overflow`=0, `o_underflow`=0. Stack RAM contents are not reset and are don't-care.
- A command is accepted only on a cycle with `mclk_en`=1, `i_halt`=0 and `i_reset`=0. Otherwise all state holds. This includes load, which is also gated by `mclk_en`.
- Fixed priority among asserted commands: `i_return` > `i_call` > `i_load_enable` > `i_counter_enable`. Lower-priority requests in the same cycle are ignored.
- INC: counter ← counter+1, modulo 2^WIDTH. Max wraps to 0.
- LOAD: counter ← `i_load_data`. Stack untouched.
- CALL, not full: stack[depth] ← counter+1 (wrapped); depth ← depth+1; counter ← `i_load_data`.
- CALL, full: counter and stack unchanged; `o_overflow` ← 1.
- RETURN, not empty: counter ← stack[depth-1]; depth ← depth-1.
- RETURN, empty: counter unchanged; `o_underflow` ← 1.
- Sticky flags clear only on `i_reset`.
- The stack is strictly LIFO. Push and pop never occur in the same cycle.
- Reset mid-sequence discards all pending stack contents; the depth count returns to 0.

## Timing
- All outputs are registered. A command accepted at edge N is visible on `o_data`, `o_depth` and the flags after edge N. Latency is 1 cycle, with no combinational input-to-output path.
- `o_stack_empty` and `o_stack_full` are decoded from the registered depth, so they are valid in the same cycle as `o_depth`.
- Back-to-back CALL/RETURN on consecutive enabled cycles is supported at full rate.
- A RETURN immediately after a CALL returns the pushed address. No bypass hazard exists, because the pop reads the already-written entry.
- A halt asserted in the same cycle as a command blocks that command. Deasserting halt resumes on the next enabled edge.

## Structure
- Shared package `sap1_pc_pkg` holds:
  - enum `pc_op_t` {`PC_HOLD`, `PC_INC`, `PC_LOAD`, `PC_CALL`, `PC_RET`};
  - function `pc_decode(halt, ret, call, load, inc)` → `pc_op_t`, which implements the priority rule.
- Sub-module `pc_return_stack` (params `WIDTH`, `DEPTH`; ports `mclk`, `i_reset`, `i_push`, `i_pop`, `i_push_data`, `o_top`, `o_depth`, `o_full`, `o_empty`). It is register-array storage plus a depth counter and does no overflow guarding. The top level qualifies `i_push` and `i_pop` with full/empty and owns the sticky flags.

## Test plan
- Reset, then 17 enabled INC cycles with WIDTH=4 → `o_data` steps 0,1,…,15,0,1. Cycles with `mclk_en`=0 interleaved leave `o_data` unchanged.
- LOAD 0x9, CALL 0x3, INC×2, RETURN → `o_data` sequence 9,3,4,5,A, with `o_depth` 0→1→0. Asserting INC with RETURN in the same cycle still yields A.
- DEPTH=4: five nested CALLs from PC=0 (targets 1,2,3,4,5) → the fifth is blocked, `o_data`=4, `o_overflow`=1, `o_stack_full`=1. Four RETURNs then give 4,3,2,1.
- Reset, then RETURN → `o_data`=0, `o_underflow`=1. A subsequent INC gives 1 with the flag still 1, and `i_reset` clears it.
- `i_halt`=1 with CALL 0x7 at PC=2 → no change. Releasing halt and repeating the CALL → `o_data`=7, and the stacked value is 3.
- Reset asserted at `o_depth`=3 together with CALL → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/sap1_pc_pkg.sv
// Shared types for the SAP-1 program counter: micro-op encoding and command priority decode.
// Pure combinational helpers; no state, no flow control.
package sap1_pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_op_t;

  // Return beats call beats load beats increment; halt masks everything.
  function automatic pc_op_t pc_decode(
    input logic halt,
    input logic ret,
    input logic call,
    input logic load,
    input logic inc
  );
    pc_op_t op;
    op = PC_HOLD;
    if (!halt) begin
      if (ret)       op = PC_RET;
      else if (call) op = PC_CALL;
      else if (load) op = PC_LOAD;
      else if (inc)  op = PC_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses: register array plus depth count, 1-cycle update, combinational top read.
// No overflow/underflow guarding; the caller must only push when not full and pop when not empty.
module pc_return_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             mclk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic [DW-1:0]    o_depth,
  output logic             o_full,
  output logic             o_empty
);

  // Storage is rounded up to a power of two so every index value is in range.
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << AW;

  logic [WIDTH-1:0] r_mem [SLOTS];
  logic [DW-1:0]    r_depth;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  assign w_wr_idx = AW'(r_depth);
  assign w_rd_idx = AW'(r_depth - DW'(1));

  always_ff @(posedge mclk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_push_data;
    end
  end

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      r_depth <= '0;
    end else if (i_push && !i_pop) begin
      r_depth <= r_depth + DW'(1);
    end else if (i_pop && !i_push) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign o_top   = r_mem[w_rd_idx];
  assign o_depth = r_depth;
  assign o_full  = (r_depth == DW'(DEPTH));
  assign o_empty = (r_depth == '0);

endmodule

// File: rtl/program_counter_stack.sv
// SAP-1 program counter with INC/LOAD/CALL/RETURN, 1-cycle registered outputs, sticky stack-error flags.
// Halt or mclk_en low freezes all state; CALL on full / RETURN on empty is dropped and flagged.
module program_counter_stack
  import sap1_pc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             mclk,
  input  logic             i_reset,
  input  logic             mclk_en,
  input  logic             i_counter_enable,
  input  logic             i_halt,
  input  logic             i_load_enable,
  input  logic             i_call,
  input  logic             i_return,
  input  logic [WIDTH-1:0] i_load_data,
  output logic [WIDTH-1:0] o_data,
  output logic [DW-1:0]    o_depth,
  output logic             o_stack_empty,
  output logic             o_stack_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [WIDTH-1:0] r_pc;
  logic             r_overflow;
  logic             r_underflow;

  pc_op_t           w_op;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ovf;
  logic             w_set_udf;

  assign w_op     = mclk_en ? pc_decode(i_halt, i_return, i_call, i_load_enable, i_counter_enable)
                            : PC_HOLD;
  assign w_pc_inc = r_pc + WIDTH'(1);

  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_udf = 1'b0;
    case (w_op)
      PC_INC:  w_pc_next = w_pc_inc;
      PC_LOAD: w_pc_next = i_load_data;
      PC_CALL: begin
        if (w_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_push    = 1'b1;
          w_pc_next = i_load_data;
        end
      end
      PC_RET: begin
        if (w_empty) begin
          w_set_udf = 1'b1;
        end else begin
          w_pop     = 1'b1;
          w_pc_next = w_top;
        end
      end
      default: w_pc_next = r_pc;
    endcase
  end

  // The pushed return address is PC+1 so RETURN resumes after the CALL.
  pc_return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .mclk        (mclk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_top),
    .o_depth     (o_depth),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      r_pc        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_set_ovf) r_overflow  <= 1'b1;
      if (w_set_udf) r_underflow <= 1'b1;
    end
  end

  assign o_data        = r_pc;
  assign o_stack_empty = w_empty;
  assign o_stack_full  = w_full;
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule
